// File: rtl/hdd_phy_pkg.sv
// Shared types and constants for the ST-506 PHY probe: FSM states, the
// noise/quality breakpoints and the quality grading function.
package hdd_phy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_INDEX,
        ST_SAMPLE,
        ST_ANALYZE,
        ST_DONE
    } state_t;

    localparam logic [7:0] QUAL_HIGH = 8'd255;
    localparam logic [7:0] QUAL_GOOD = 8'd200;
    localparam logic [7:0] QUAL_FAIR = 8'd128;
    localparam logic [7:0] QUAL_POOR = 8'd64;

    localparam logic [7:0] NOISE_BP_HIGH = 8'd20;
    localparam logic [7:0] NOISE_BP_GOOD = 8'd50;
    localparam logic [7:0] NOISE_BP_FAIR = 8'd100;
    localparam logic [7:0] NOISE_BP_SAT  = 8'd200;
    localparam logic [7:0] NOISE_SAT     = 8'd255;

    // A lane without signal grades 0 regardless of its noise figure.
    function automatic logic [7:0] quality_of(input logic present, input logic [7:0] noise);
        if (!present)                 return 8'd0;
        else if (noise < NOISE_BP_HIGH) return QUAL_HIGH;
        else if (noise < NOISE_BP_GOOD) return QUAL_GOOD;
        else if (noise < NOISE_BP_FAIR) return QUAL_FAIR;
        else                          return QUAL_POOR;
    endfunction

endpackage

// File: rtl/hdd_phy_probe_lane.sv
// One probe lane: SE and differential edge statistics gathered side by side,
// then a one-cycle analysis that picks the stronger path and grades it.
module hdd_phy_probe_lane
    import hdd_phy_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MIN_EDGES   = 1000,
    parameter int DIFF_MARGIN = 500,
    parameter int RAPID_LIMIT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_sample_en,
    input  logic             i_analyze_en,
    input  logic             i_mask,
    input  logic             i_rd_se,
    input  logic             i_rd_p,
    input  logic             i_rd_n,
    output logic             o_is_diff,
    output logic             o_signal_present,
    output logic             o_termination_ok,
    output logic [CNT_W-1:0] o_edge_count,
    output logic [7:0]       o_noise_score,
    output logic [7:0]       o_signal_quality,
    output logic [CNT_W-1:0] o_min_pw,
    output logic [CNT_W-1:0] o_max_pw
);

    // Path 0 is single-ended, path 1 is the differential pair.
    logic [1:0]       w_smp;
    logic [1:0]       r_prev;
    logic [1:0]       r_seen;
    logic [CNT_W-1:0] r_edges [2];
    logic [CNT_W-1:0] r_ivl   [2];
    logic [CNT_W-1:0] r_min   [2];
    logic [CNT_W-1:0] r_max   [2];
    logic [7:0]       r_rapid [2];

    assign w_smp = {i_rd_p ^ i_rd_n, i_rd_se};

    // NOTE: these per-path arrays are plain flops, not RAM, so they take the reset like any register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev <= '0;
            r_seen <= '0;
            for (int p = 0; p < 2; p++) begin
                r_edges[p] <= '0;
                r_ivl[p]   <= '0;
                r_min[p]   <= '1;
                r_max[p]   <= '0;
                r_rapid[p] <= '0;
            end
        end else begin
            r_prev <= w_smp;
            for (int p = 0; p < 2; p++) begin
                if (i_clear) begin
                    r_seen[p]  <= 1'b0;
                    r_edges[p] <= '0;
                    r_ivl[p]   <= '0;
                    r_min[p]   <= '1;
                    r_max[p]   <= '0;
                    r_rapid[p] <= '0;
                end else if (i_sample_en) begin
                    if (w_smp[p] != r_prev[p]) begin
                        r_seen[p] <= 1'b1;
                        r_ivl[p]  <= '0;
                        if (r_edges[p] != '1) r_edges[p] <= r_edges[p] + 1'b1;
                        // The interval leading up to the first edge has no real start point.
                        if (r_seen[p]) begin
                            if (r_ivl[p] < r_min[p]) r_min[p] <= r_ivl[p];
                            if (r_ivl[p] > r_max[p]) r_max[p] <= r_ivl[p];
                            if (r_ivl[p] < CNT_W'(RAPID_LIMIT) && r_rapid[p] != 8'hFF)
                                r_rapid[p] <= r_rapid[p] + 8'd1;
                        end
                    end else if (r_ivl[p] != '1) begin
                        r_ivl[p] <= r_ivl[p] + 1'b1;
                    end
                end
            end
        end
    end

    logic [CNT_W:0]   w_se_plus_margin;
    logic             w_is_diff;
    logic             w_present;
    logic             w_two;
    logic [7:0]       w_noise;
    logic [CNT_W-1:0] w_min;
    logic [CNT_W-1:0] w_max;
    logic             w_term;

    // One extra bit keeps se_edges + margin from wrapping.
    assign w_se_plus_margin = {1'b0, r_edges[0]} + (CNT_W+1)'(DIFF_MARGIN);
    assign w_is_diff = {1'b0, r_edges[1]} > w_se_plus_margin;
    assign w_present = (r_edges[0] > CNT_W'(MIN_EDGES)) || (r_edges[1] > CNT_W'(MIN_EDGES));
    assign w_two     = r_edges[w_is_diff] >= CNT_W'(2);
    assign w_noise   = (r_rapid[w_is_diff] > NOISE_BP_SAT) ? NOISE_SAT : r_rapid[w_is_diff];
    assign w_min     = w_two ? r_min[w_is_diff] : '0;
    assign w_max     = w_two ? r_max[w_is_diff] : '0;
    assign w_term    = w_two && ((w_max - w_min) < (w_min >> 1));

    always_ff @(posedge clk) begin
        if (reset || (i_analyze_en && !i_mask)) begin
            o_is_diff        <= 1'b0;
            o_signal_present <= 1'b0;
            o_termination_ok <= 1'b0;
            o_edge_count     <= '0;
            o_noise_score    <= '0;
            o_signal_quality <= '0;
            o_min_pw         <= '0;
            o_max_pw         <= '0;
        end else if (i_analyze_en) begin
            o_is_diff        <= w_is_diff;
            o_signal_present <= w_present;
            o_termination_ok <= w_term;
            o_edge_count     <= r_edges[w_is_diff];
            o_noise_score    <= w_noise;
            o_signal_quality <= quality_of(w_present, w_noise);
            o_min_pw         <= w_min;
            o_max_pw         <= w_max;
        end
    end

endmodule

// File: rtl/hdd_phy_probe_mc.sv
// Multi-channel ST-506 PHY probe: index-synchronised sampling window shared
// by NUM_CH lanes, with abort and one-cycle result commit.
module hdd_phy_probe_mc
    import hdd_phy_pkg::*;
#(
    parameter int NUM_CH        = 2,
    parameter int CNT_W         = 16,
    parameter int WIN_W         = 24,
    parameter int WINDOW_CYCLES = 1_500_000,
    parameter int INDEX_TIMEOUT = 1_500_000,
    parameter int MIN_EDGES     = 1000,
    parameter int DIFF_MARGIN   = 500,
    parameter int RAPID_LIMIT   = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    probe_start,
    input  logic                    probe_abort,
    input  logic [NUM_CH-1:0]       ch_mask,
    input  logic [NUM_CH-1:0]       read_data_se,
    input  logic [NUM_CH-1:0]       read_data_p,
    input  logic [NUM_CH-1:0]       read_data_n,
    input  logic                    index_pulse,
    output logic                    probe_busy,
    output logic                    probe_done,
    output logic                    probe_aborted,
    output logic                    index_seen,
    output logic [NUM_CH-1:0]       is_diff,
    output logic [NUM_CH-1:0]       signal_present,
    output logic [NUM_CH-1:0]       termination_ok,
    output logic [NUM_CH*CNT_W-1:0] edge_count,
    output logic [NUM_CH*8-1:0]     noise_score,
    output logic [NUM_CH*8-1:0]     signal_quality,
    output logic [NUM_CH*CNT_W-1:0] min_pw,
    output logic [NUM_CH*CNT_W-1:0] max_pw
);

    localparam logic [WIN_W-1:0] TIMEOUT_LAST = WIN_W'(INDEX_TIMEOUT - 1);
    localparam logic [WIN_W-1:0] WINDOW_LAST  = WIN_W'(WINDOW_CYCLES - 1);

    state_t             r_state;
    state_t             w_next;
    logic [WIN_W-1:0]   r_cnt;
    logic [NUM_CH-1:0]  r_mask;
    logic               r_index_prev;
    logic               r_index_hit;
    logic               r_aborted;
    logic               r_index_seen;
    logic               w_index_rise;
    logic               w_clear;
    logic               w_abort_hit;
    logic               w_sample_en;
    logic               w_analyze_en;

    // r_index_prev tracks the pin every cycle, so a level already high on entry is not an edge.
    assign w_index_rise = index_pulse & ~r_index_prev;

    // NOTE: every combinational output gets a default before the case, so no path leaves it unassigned (no latch).
    always_comb begin
        w_next      = r_state;
        w_clear     = 1'b0;
        w_abort_hit = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (probe_start && !probe_abort) begin
                    w_next  = ST_WAIT_INDEX;
                    w_clear = 1'b1;
                end
            end
            ST_WAIT_INDEX: begin
                if (probe_abort) begin
                    w_next      = ST_IDLE;
                    w_abort_hit = 1'b1;
                end else if (w_index_rise || r_cnt == TIMEOUT_LAST) begin
                    w_next = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (probe_abort) begin
                    w_next      = ST_IDLE;
                    w_abort_hit = 1'b1;
                end else if (r_cnt == WINDOW_LAST) begin
                    w_next = ST_ANALYZE;
                end
            end
            ST_ANALYZE: begin
                if (probe_abort) begin
                    w_next      = ST_IDLE;
                    w_abort_hit = 1'b1;
                end else begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    assign w_sample_en  = (r_state == ST_SAMPLE);
    assign w_analyze_en = (r_state == ST_ANALYZE) && !probe_abort;

    // NOTE: all state here is updated with <= so every register sees the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_mask       <= '0;
            r_index_prev <= 1'b0;
            r_index_hit  <= 1'b0;
            r_aborted    <= 1'b0;
            r_index_seen <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_index_prev <= index_pulse;
            r_aborted    <= w_abort_hit;
            // The counter restarts on every state change, serving as timeout then window length.
            if (r_state == ST_IDLE || r_state != w_next) r_cnt <= '0;
            else                                         r_cnt <= r_cnt + 1'b1;
            if (w_clear) r_mask <= ch_mask;
            if (r_state == ST_WAIT_INDEX && w_next == ST_SAMPLE) r_index_hit <= w_index_rise;
            if (w_analyze_en) r_index_seen <= r_index_hit;
        end
    end

    assign probe_busy    = (r_state == ST_WAIT_INDEX) || (r_state == ST_SAMPLE) || (r_state == ST_ANALYZE);
    assign probe_done    = (r_state == ST_DONE);
    assign probe_aborted = r_aborted;
    assign index_seen    = r_index_seen;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        hdd_phy_probe_lane #(
            .CNT_W       (CNT_W),
            .MIN_EDGES   (MIN_EDGES),
            .DIFF_MARGIN (DIFF_MARGIN),
            .RAPID_LIMIT (RAPID_LIMIT)
        ) u_lane (
            .clk              (clk),
            .reset            (reset),
            .i_clear          (w_clear),
            .i_sample_en      (w_sample_en),
            .i_analyze_en     (w_analyze_en),
            .i_mask           (r_mask[c]),
            .i_rd_se          (read_data_se[c]),
            .i_rd_p           (read_data_p[c]),
            .i_rd_n           (read_data_n[c]),
            .o_is_diff        (is_diff[c]),
            .o_signal_present (signal_present[c]),
            .o_termination_ok (termination_ok[c]),
            .o_edge_count     (edge_count[c*CNT_W +: CNT_W]),
            .o_noise_score    (noise_score[c*8 +: 8]),
            .o_signal_quality (signal_quality[c*8 +: 8]),
            .o_min_pw         (min_pw[c*CNT_W +: CNT_W]),
            .o_max_pw         (max_pw[c*CNT_W +: CNT_W])
        );
    end

endmodule

// File: doc/hdd_phy_probe_mc.md
# hdd_phy_probe_mc

Multi-channel, parametrised ST-506 physical-layer probe. It samples the single-ended and differential read-data paths of up to NUM_CH drive channels concurrently within one index-synchronised window. For each channel it reports signalling type, edge count, noise score, quality, pulse-width extremes and a termination verdict. It is the first stage of the HDD discovery pipeline and feeds the PHY mode controller once per channel.

## Interface
Parameters:
- NUM_CH, 2: number of drive channels probed in parallel (1..4).
- CNT_W, 16: width of edge and pulse-width counters.
- WIN_W, 24: width of the window and timeout counters.
- WINDOW_CYCLES, 1_500_000: length of the sample window in clk cycles (5 ms at 300 MHz).
- INDEX_TIMEOUT, 1_500_000: number of cycles to wait for an index rising edge.
- MIN_EDGES, 1000: a channel needs more edges than this to count as signal present.
- DIFF_MARGIN, 500: the differential edge count must exceed the SE count by more than this to classify the channel as differential.
- RAPID_LIMIT, 10: an interval shorter than this many cycles counts as a rapid (noise) transition.

Ports:
- clk  in  1  clock, 300 MHz HDD domain.
- reset  in  1  synchronous, active-high.
- probe_start  in  1  start request; honoured only in IDLE.
- probe_abort  in  1  abort request; honoured in any non-IDLE state.
- ch_mask  in  NUM_CH  channel enables, captured at start.
- read_data_se  in  NUM_CH  SE read data; already synchronised upstream.
- read_data_p / read_data_n  in  NUM_CH each  differential pair.
- index_pulse  in  1  index from the selected drive.
- probe_busy  out  1  high from the cycle after start until done or abort.
- probe_done  out  1  one-cycle pulse when results update.
- probe_aborted  out  1  one-cycle pulse on abort.
- index_seen  out  1  1 = window started on an index edge; 0 = started on timeout.
- is_diff  out  NUM_CH  per-channel signalling type.
- signal_present  out  NUM_CH  per-channel signal flag.
- termination_ok  out  NUM_CH  per-channel termination verdict.
- edge_count  out  NUM_CH*CNT_W  edge count of the chosen path; channel c is in bits [c*CNT_W +: CNT_W].
- noise_score  out  NUM_CH*8  per-channel noise score.
- signal_quality  out  NUM_CH*8  per-channel quality.
- min_pw / max_pw  out  NUM_CH*CNT_W each  pulse-width extremes of the chosen path.

## Operation
- States: IDLE, WAIT_INDEX, SAMPLE, ANALYZE, DONE.
- IDLE → WAIT_INDEX on probe_start. On that transition:
  - capture ch_mask;
  - clear all lane statistics;
  - clear the timeout counter.
- WAIT_INDEX → SAMPLE on the first index_pulse rising edge (index_seen=1), or when the timeout counter reaches INDEX_TIMEOUT-1 (index_seen=0).
  - A level that is already high on entry does not count as an edge.
- SAMPLE:
  - Lasts exactly WINDOW_CYCLES cycles.
  - Both paths are sampled simultaneously on every lane.
  - The differential path is diff = p XOR n.
  - An edge is the current sample differing from the previous registered sample.
- Per lane and per path:
  - The edge counter saturates at all-ones.
  - The interval counter clears on each edge and saturates at all-ones.
  - On each edge after the first: update min/max with the interval, and increment the rapid count (8-bit, saturating) if interval < RAPID_LIMIT.
  - The interval before the first edge is discarded.
- ANALYZE (one cycle, all lanes in parallel):
  - is_diff = diff_edges > se_edges + DIFF_MARGIN, evaluated in CNT_W+1 bits so the sum never wraps.
  - The chosen path is diff if is_diff, else SE. edge_count, min_pw, max_pw and the rapid count are taken from the chosen path.
  - signal_present = (se_edges > MIN_EDGES) or (diff_edges > MIN_EDGES).
  - noise_score = 255 if rapid > 200, else rapid.
  - signal_quality uses the noise value computed in this same cycle: 0 if not present; otherwise 255 if noise <20, 200 if <50, 128 if <100, else 64.
  - termination_ok requires at least 2 edges on the chosen path and (max_pw − min_pw) < (min_pw >> 1).
  - When fewer than 2 edges: min_pw and max_pw read 0.
- Masked lanes report all zeros.
- DONE: register the results, pulse probe_done, then go to IDLE.
- Abort in WAIT_INDEX, SAMPLE or ANALYZE:
  - go to IDLE next cycle and pulse probe_aborted;
  - result outputs keep their previous values.
- probe_start while busy is ignored.
- If start and abort arrive together in IDLE, abort wins: no probe starts and no pulse is issued.

## Timing
- Reset: every output is 0 and the state is IDLE.
- A start sampled at edge T gives probe_busy=1 from T+1.
- With an index rising edge detected at cycle I, SAMPLE covers I+1 .. I+WINDOW_CYCLES, ANALYZE is at I+WINDOW_CYCLES+1, and probe_done is high at I+WINDOW_CYCLES+2.
- Results and index_seen change only in the cycle probe_done is high.
- probe_busy falls in the same cycle as probe_done or probe_aborted.
- Minimum restart: a new start is accepted the cycle after done.

## Structure
- Package hdd_phy_pkg holds:
  - the state enum;
  - quality levels 255/200/128/64 and noise breakpoints 20/50/100/200;
  - the noise saturation value 255.
- One sub-module, hdd_phy_probe_lane, instantiated NUM_CH times. It contains the edge detect, counters and per-lane analysis, and its inputs are clear, sample_en, analyze_en and mask.
- The top level holds the FSM, index edge detect and the timeout/window counter.

## Test plan
Bench parameters: WINDOW_CYCLES=1000, INDEX_TIMEOUT=200, MIN_EDGES=50, DIFF_MARGIN=20.

- SE lane 0 toggling every 8 cycles, diff constant, index edge at cycle 30 → edge_count[0]=125, is_diff[0]=0, signal_present[0]=1, termination_ok[0]=1, noise 0, quality 255, index_seen=1.
- Lane 1 p toggling every 8 cycles, SE idle, no index → start of window at the 200-cycle timeout, index_seen=0, is_diff[1]=1, edge_count[1]=125.
- SE with a 3-cycle glitch pair inserted every 20 cycles → rapid count >100, noise_score saturates per rule, quality 64.
- Silent lines → signal_present=0, quality 0, termination_ok=0, min_pw=max_pw=0.
- Abort at cycle 500 of SAMPLE → probe_aborted pulse, results unchanged from the previous run, busy drops the same cycle.
- ch_mask=2'b10 with both lanes active → all lane-0 results 0; start and abort together in IDLE → no busy.
